// File: rtl/e_mul_div_unit.sv
// rtl/e_mul_div_unit.sv - execute-stage multiply/divide unit owning HI/LO
module e_mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     p_hi, p_lo;
  logic            p_write;
  logic            commit;

  logic            is_md, is_div, signed_op, div_zero, write_d;
  logic [63:0]     mul_a, mul_b, mul_p, res_d;
  logic signed [32:0] div_a, div_b, div_q, div_r;
  logic            unused_div_msb;

  // Operand conditioning and the 64-bit result computed in the issue cycle
  always_comb begin
    is_md     = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
    signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
    div_zero  = (rt_val == 32'd0);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned multiply.
    mul_a = {{32{signed_op & rs_val[31]}}, rs_val};
    mul_b = {{32{signed_op & rt_val[31]}}, rt_val};
    mul_p = mul_a * mul_b;

    // 33-bit signed divide covers both flavours and keeps the
    // 0x80000000 / -1 case from overflowing (quotient truncates to 0x80000000).
    div_a = $signed({signed_op & rs_val[31], rs_val});
    div_b = $signed({signed_op & rt_val[31], rt_val});
    if (div_zero) begin
      div_b = 33'sd1;
    end
    div_q = div_a / div_b;
    div_r = div_a % div_b;

    res_d   = is_div ? {div_r[31:0], div_q[31:0]} : mul_p;
    write_d = !(is_div && div_zero);
  end

  assign unused_div_msb = div_q[32] ^ div_r[32];

  assign md_busy  = (state_q == S_BUSY);
  assign md_start = is_md && !md_busy;

  // Architectural read port: no bypass of pending or same-cycle writes
  always_comb begin
    md_out = 32'd0;
    if (md_op == OP_MFHI) begin
      md_out = hi;
    end else if (md_op == OP_MFLO) begin
      md_out = lo;
    end
  end

  // Next-state logic for the busy sequencer and its countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          state_d = S_BUSY;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, countdown and pending result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_hi    <= 32'd0;
      p_lo    <= 32'd0;
      p_write <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (md_start) begin
        {p_hi, p_lo} <= res_d;
        p_write      <= write_d;
      end
    end
  end

  // HI/LO update: completion of a mult/div or a direct move when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      if (p_write) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end else if (!md_busy) begin
      if (md_op == OP_MTHI) begin
        hi <= rs_val;
      end
      if (md_op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_e_mul_div_unit.sv
// tb/tb_e_mul_div_unit.sv - scoreboard bench for e_mul_div_unit
module tb_e_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_start, md_busy;
  logic [31:0] md_out, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } done_t;

  done_t       done_q[$];
  logic [31:0] out_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  e_mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .md_start(md_start), .md_busy(md_busy), .md_out(md_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pops expectations on completion (busy falling) and on mfhi/mflo
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    done_t d;
    logic [31:0] e;
    if (md_op == 4'd7 || md_op == 4'd8) begin
      if (out_q.size() == 0) begin
        chk("md_out_unexpected", md_out, 32'hxxxxxxxx);
      end else begin
        e = out_q.pop_front();
        chk($sformatf("md_out op%0d", md_op), md_out, e);
      end
    end
    if (md_busy) busy_cnt++;
    if (prev_busy && !md_busy) begin
      if (done_q.size() == 0) begin
        chk("completion_unexpected", 32'(busy_cnt), 32'hxxxxxxxx);
      end else begin
        d = done_q.pop_front();
        chk("done_hi", hi, d.hi);
        chk("done_lo", lo, d.lo);
        chk("busy_cycles", 32'(busy_cnt), 32'(d.cyc));
      end
      busy_cnt = 0;
    end
    prev_busy = md_busy;
  end

  task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic es);
    md_op  = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    chk($sformatf("md_start op%0d", o), 32'(md_start), 32'(es));
    @(posedge clk);
    #1;
    md_op = 4'd0;
  endtask

  task automatic push_done(input logic [31:0] h, input logic [31:0] l, input int c);
    done_t d;
    d.hi = h;
    d.lo = l;
    d.cyc = c;
    done_q.push_back(d);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (md_busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(md_busy), 32'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // mult -3*7, then multu back-to-back in the cycle busy drops
    push_done(32'hFFFFFFFF, 32'hFFFFFFEB, 5);
    op(4'd1, 32'hFFFFFFFD, 32'd7, 1'b1);
    wait_idle();
    push_done(32'h00000001, 32'hFFFFFFFE, 5);
    op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_idle();

    // signed/unsigned divides including the overflow case
    push_done(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle();
    push_done(32'h00000000, 32'h80000000, 10);
    op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle();
    push_done(32'd2, 32'd14, 10);
    op(4'd4, 32'd100, 32'd7, 1'b1);
    wait_idle();

    // preload then divide by zero keeps hi/lo
    op(4'd5, 32'h11, 32'd0, 1'b0);
    op(4'd6, 32'h22, 32'd0, 1'b0);
    out_q.push_back(32'h11);
    op(4'd7, 32'd0, 32'd0, 1'b0);
    push_done(32'h11, 32'h22, 10);
    op(4'd4, 32'd5, 32'd0, 1'b1);
    wait_idle();
    out_q.push_back(32'h22);
    op(4'd8, 32'd0, 32'd0, 1'b0);

    // mthi then mfhi next cycle; ops issued while busy are ignored
    op(4'd5, 32'h1234, 32'd0, 1'b0);
    out_q.push_back(32'h1234);
    op(4'd7, 32'd0, 32'd0, 1'b0);
    push_done(32'd0, 32'd12, 5);
    op(4'd1, 32'd3, 32'd4, 1'b1);
    op(4'd1, 32'd9, 32'd9, 1'b0);
    op(4'd5, 32'hDEAD, 32'd0, 1'b0);
    op(4'd3, 32'd50, 32'd5, 1'b0);
    wait_idle();
    out_q.push_back(32'd0);
    op(4'd7, 32'd0, 32'd0, 1'b0);
    out_q.push_back(32'd12);
    op(4'd8, 32'd0, 32'd0, 1'b0);

    // undefined op codes: no start, md_out zero
    op(4'd9, 32'd1, 32'd1, 1'b0);
    md_op = 4'd15;
    @(negedge clk);
    chk("md_out_op15", md_out, 32'd0);
    idle_cycle();
    md_op = 4'd0;

    // reset in 4th busy cycle of a div, then mult right after reset drops
    op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    reset = 1'b1;
    push_done(32'd0, 32'd0, 4);
    idle_cycle();
    reset = 1'b0;
    push_done(32'd0, 32'd6, 5);
    op(4'd1, 32'd2, 32'd3, 1'b1);
    wait_idle();

    idle_cycle();
    idle_cycle();
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    chk("out_q_drained", 32'(out_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
